// File: rtl/trig_capture_fifo.sv
// Trigger-tap capture FIFO: timestamps selected counter carry pulses and buffers them for a valid/ready consumer.
// Optional dropped-event counter is built when TRIG_CAPTURE_DROP_CNT_EN is defined.
module trig_capture_fifo #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 8,
   parameter int DROP_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           count,
   input  logic [WIDTH-1:0]           trig_in,
   input  logic [$clog2(WIDTH)-1:0]   tap_sel,
   input  logic                       arm,
   input  logic                       oneshot,
   output logic                       ev_valid,
   input  logic                       ev_ready,
   output logic [WIDTH-1:0]           ev_count,
   output logic [WIDTH-1:0]           ev_trig,
   output logic [$clog2(DEPTH):0]     level,
   output logic [1:0]                 state,
   output logic [DROP_W-1:0]          drop_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic                 hit;
   logic                 cap;
   logic                 full;
   logic                 pop;
   logic                 push;
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [LVL_W-1:0]     level_q;
   logic [2*WIDTH-1:0]   mem [DEPTH];
   logic [2*WIDTH-1:0]   head;

   // An out-of-range tap index (possible for non power-of-two WIDTH) never hits.
   always_comb begin
      hit = 1'b0;
      if (int'(tap_sel) < WIDTH) begin
         hit = trig_in[tap_sel];
      end
   end

   assign cap  = hit && (state_q == ARMED);
   assign full = (level_q == LVL_W'(DEPTH));
   assign pop  = ev_valid && ev_ready;
   assign push = cap && (!full || pop);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (arm) state_d = ARMED;
         ARMED: begin
            if (!arm)                  state_d = IDLE;
            else if (cap && oneshot)   state_d = HOLD;
         end
         HOLD:    if (!arm) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      level_q <= level_q + LVL_W'(1);
         else if (pop && !push) level_q <= level_q - LVL_W'(1);
      end
   end

   // Storage is left unreset; empty-FIFO outputs are masked to zero instead.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {count, trig_in};
      end
   end

   assign head     = mem[rd_ptr];
   assign ev_valid = (level_q != '0);
   assign ev_count = ev_valid ? head[2*WIDTH-1:WIDTH] : '0;
   assign ev_trig  = ev_valid ? head[WIDTH-1:0] : '0;
   assign level    = level_q;
   assign state    = state_q;

`ifdef TRIG_CAPTURE_DROP_CNT_EN
   logic              drop;
   logic [DROP_W-1:0] drop_q;

   assign drop = cap && full && !pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_q <= '0;
      end else if (drop && (drop_q != '1)) begin
         drop_q <= drop_q + DROP_W'(1);
      end
   end

   assign drop_cnt = drop_q;
`else
   assign drop_cnt = '0;
`endif

endmodule
